rect_frame_sequencer: RTL

//  Scan/frame controller for the stereo rectification stage. Generates the ix/iy pixel

---
 rtl/rect_frame_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/rect_frame_sequencer.sv
// Purpose     : raster scan generator (ix/iy) and double-buffered 3x3 homography banks
//               for the stereo rectifier; coefficients go live only at a frame boundary.
// Latency     : all outputs registered; one pixel per clk; a commit lands at the next
//               (0,0) edge when scanning, or one edge after busy rises when idle.
// Backpressure: none on the scan; cfg writes are dropped (cfg_err pulse) while busy.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   en                     run request (level)
//   cfg_wr/addr/data       shadow coefficient write (0..8 = A, 9..17 = B)
//   cfg_commit, cfg_busy   shadow->live request, pending flag
//   cfg_err                one-cycle pulse for a dropped write
//   ix, iy, active         scan position and active-area flag
//   frame_start, running   (0,0) pulse, scanner not idle
//   coef_a, coef_b         live banks, H11 in the low word .. H33 in the top word
module rect_frame_sequencer #(
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int CW       = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            cfg_wr,
  input  logic [4:0]      cfg_addr,
  input  logic [CW-1:0]   cfg_data,
  input  logic            cfg_commit,
  output logic            cfg_busy,
  output logic            cfg_err,
  output logic [31:0]     ix,
  output logic [31:0]     iy,
  output logic            active,
  output logic            frame_start,
  output logic [9*CW-1:0] coef_a,
  output logic [9*CW-1:0] coef_b,
  output logic            running
);

  typedef logic [8:0][CW-1:0] bank_t;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  // Identity homography: H11 (word 0), H22 (word 4), H33 (word 8) = 1.
  localparam bank_t IDENT = bank_t'({CW'(1), {3{CW'(0)}}, CW'(1), {3{CW'(0)}}, CW'(1)});

  localparam logic [31:0] IX_LAST = 32'(H_TOTAL - 1);
  localparam logic [31:0] IY_LAST = 32'(V_TOTAL - 1);
  localparam logic [31:0] IX_ACT  = 32'(H_ACTIVE);
  localparam logic [31:0] IY_ACT  = 32'(V_ACTIVE);

  state_t      state, state_nx;
  logic [31:0] ix_nx, iy_nx;
  logic        fs_nx, act_nx, busy_nx, xfer, wr_ok;
  logic        last_col, last_row;
  bank_t       shadow_a, shadow_b, live_a, live_b;

  assign last_col = (ix == IX_LAST);
  assign last_row = (iy == IY_LAST);
  assign coef_a   = live_a;
  assign coef_b   = live_b;

  // Next-state, next-position and transfer decision.
  always_comb begin
    state_nx = state;
    ix_nx    = ix;
    iy_nx    = iy;
    fs_nx    = 1'b0;
    xfer     = 1'b0;
    case (state)
      IDLE: begin
        ix_nx = '0;
        iy_nx = '0;
        // A pending commit in IDLE lands on the very next edge.
        xfer  = cfg_busy;
        if (en) begin
          state_nx = RUN;
          fs_nx    = 1'b1;
        end
      end
      RUN, DRAIN: begin
        if (state == RUN && !en) begin
          state_nx = DRAIN;
        end else if (state == DRAIN && en) begin
          state_nx = RUN;
        end
        if (last_col) begin
          ix_nx = '0;
          iy_nx = last_row ? '0 : iy + 32'd1;
        end else begin
          ix_nx = ix + 32'd1;
        end
        // Frame boundary: the edge that presents (0,0) also swaps the banks.
        if (last_col && last_row) begin
          xfer = cfg_busy;
          if (state == DRAIN && !en) begin
            state_nx = IDLE;
          end else begin
            fs_nx = 1'b1;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        ix_nx    = '0;
        iy_nx    = '0;
      end
    endcase
    act_nx  = (state_nx != IDLE) && (ix_nx < IX_ACT) && (iy_nx < IY_ACT);
    // xfer implies busy, so a commit arriving while busy is ignored.
    busy_nx = xfer ? 1'b0 : (cfg_busy | cfg_commit);
    wr_ok   = cfg_wr && !cfg_busy && (cfg_addr <= 5'd17);
  end

  // Scan state and registered scan outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ix          <= '0;
      iy          <= '0;
      frame_start <= 1'b0;
      active      <= 1'b0;
      running     <= 1'b0;
    end else begin
      state       <= state_nx;
      ix          <= ix_nx;
      iy          <= iy_nx;
      frame_start <= fs_nx;
      active      <= act_nx;
      running     <= (state_nx != IDLE);
    end
  end

  // Shadow/live coefficient banks and commit handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_a <= IDENT;
      shadow_b <= IDENT;
      live_a   <= IDENT;
      live_b   <= IDENT;
      cfg_busy <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_busy <= busy_nx;
      cfg_err  <= cfg_wr && !wr_ok;
      // Live takes the shadow value from before this edge; a write on the same
      // edge cannot race it because writes are blocked while busy.
      if (xfer) begin
        live_a <= shadow_a;
        live_b <= shadow_b;
      end
      if (wr_ok) begin
        for (int i = 0; i < 9; i++) begin
          if (cfg_addr == 5'(i))     shadow_a[i] <= cfg_data;
          if (cfg_addr == 5'(i + 9)) shadow_b[i] <= cfg_data;
        end
      end
    end
  end

endmodule
